// File: rtl/matmul_seq.sv
// NxN signed integer matrix-multiply sequencer (C = A x B) on a shared single-port data memory.
// Build option MATMUL_SAT_EN: out-of-range C elements saturate instead of wrapping.

module matmul_seq #(
  parameter int DW = 32,
  parameter int AW = 16,
  parameter int N  = 3
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_c,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | waiting for start
  // RD_A  | read A[i][k]
  // RD_B  | capture A element, read B[k][j]
  // MAC   | acc += a * b
  // WR    | write C[i][j], check range
  // DONE  | one-cycle completion pulse
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_B = 3'd2;
  localparam logic [2:0] MAC  = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int ACCW = 2*DW + $clog2(N) + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [AW-1:0] N_A  = AW'(N);

  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [DW-1:0]          a_q, a_d;
  logic [AW-1:0]          ba_q, ba_d, bb_q, bb_d, bc_q, bc_d;
  logic                   ovf_q, ovf_d;

  logic signed [2*DW-1:0] a_ext, b_ext, prod;
  logic signed [ACCW-1:0] prod_ext;
  logic                   fits;
  logic [DW-1:0]          result;
  logic [AW-1:0]          i_a, j_a, k_a;

  assign a_ext    = {{DW{a_q[DW-1]}}, a_q};
  assign b_ext    = {{DW{mem_rdata[DW-1]}}, mem_rdata};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

  // acc fits in DW signed when every bit from DW-1 upward equals the sign
  assign fits = (&acc_q[ACCW-1:DW-1]) | ~(|acc_q[ACCW-1:DW-1]);

`ifdef MATMUL_SAT_EN
  assign result = fits ? acc_q[DW-1:0]
                       : (acc_q[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
`else
  assign result = acc_q[DW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_d     = a_q;
    ba_d    = ba_q;
    bb_d    = bb_q;
    bc_d    = bc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ba_d    = base_a;
          bb_d    = base_b;
          bc_d    = base_c;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_d     = mem_rdata;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = WR;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = RD_A;
        end
      end
      WR: begin
        if (!fits) ovf_d = 1'b1;
        acc_d = '0;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = RD_A;
          end
        end else begin
          j_d     = j_q + 1'b1;
          state_d = RD_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      bc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      ba_q    <= ba_d;
      bb_q    <= bb_d;
      bc_q    <= bc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign i_a = AW'(i_q);
  assign j_a = AW'(j_q);
  assign k_a = AW'(k_q);

  // Outputs decode only registered state, so nothing from start/mem_rdata reaches them
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    ovf       = ovf_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      RD_A: begin
        mem_rd   = 1'b1;
        mem_addr = ba_q + i_a * N_A + k_a;
      end
      RD_B: begin
        mem_rd   = 1'b1;
        mem_addr = bb_q + k_a * N_A + j_a;
      end
      WR: begin
        mem_wr    = 1'b1;
        mem_addr  = bc_q + i_a * N_A + j_a;
        mem_wdata = result;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: memory model, behavioural C = A x B reference and a per-cycle write checker.
// Follows MATMUL_SAT_EN the same way the design does.

module tb_matmul_seq;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int N    = 3;
  // edge at which a synchronous consumer first samples done=1, counting the start edge as 0
  localparam int LAT  = N*N*(3*N+1) + 1;
  localparam int LAT2 = 2*2*(3*2+1) + 1;

  typedef int mat_t [9];
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_a = '0, base_b = '0, base_c = '0;
  logic          busy, done, ovf, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic          start2 = 1'b0;
  logic          busy2, done2, ovf2, mem_rd2, mem_wr2;
  logic [AW-1:0] mem_addr2;
  logic [DW-1:0] mem_wdata2;
  logic [DW-1:0] mem_rdata2 = '0;

  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  exp_q [$];
  wr_t  e_mon;
  int   w2_idx = 0;
  int   c2_exp [4] = '{9, 22, -13, -50};

  mat_t A1, AO, BO, AR, BR, AS, BS;

  always #5 CLK = ~CLK;

  matmul_seq #(.DW(DW), .AW(AW), .N(N)) u_dut (
    .CLK(CLK), .reset(reset), .start(start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done), .ovf(ovf),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  matmul_seq #(.DW(DW), .AW(AW), .N(2)) u_dut2 (
    .CLK(CLK), .reset(reset), .start(start2),
    .base_a(16'd0), .base_b(16'd4), .base_c(16'd8),
    .busy(busy2), .done(done2), .ovf(ovf2),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  function automatic logic [31:0] rom2(input logic [AW-1:0] a);
    case (a)
      16'd0:   return 32'hFFFF_FFFF;  // A = [-1, 2; 3, -4]
      16'd1:   return 32'd2;
      16'd2:   return 32'd3;
      16'd3:   return 32'hFFFF_FFFC;
      16'd4:   return 32'd5;          // B = [5, -6; 7, 8]
      16'd5:   return 32'hFFFF_FFFA;
      16'd6:   return 32'd7;
      16'd7:   return 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd)  mem_rdata  <= mem[mem_addr];
    if (mem_rd2) mem_rdata2 <= rom2(mem_addr2);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic signed [66:0] dot(input mat_t A, input mat_t B, input int i, input int j);
    logic signed [66:0] s, x, y;
    s = '0;
    for (int k = 0; k < 3; k++) begin
      x = A[i*3+k];
      y = B[k*3+j];
      s = s + x * y;
    end
    return s;
  endfunction

  function automatic bit in_range(input logic signed [66:0] s);
    return (s >= -67'sd2147483648) && (s <= 67'sd2147483647);
  endfunction

  function automatic logic [31:0] res(input logic signed [66:0] s);
    logic [31:0] r;
    r = s[31:0];
`ifdef MATMUL_SAT_EN
    if (!in_range(s)) r = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  // Per-cycle bus checker; every write is matched in order against the reference queue
  always @(negedge CLK) begin
    if (reset) begin
      chk("rd_wr_excl", mem_rd & mem_wr, 64'd0);
      chk("bus_idle", (!busy || done) && (mem_rd || mem_wr), 64'd0);
      if (mem_wr) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wr: write at %0h data %0h, none required", mem_addr, mem_wdata);
        end else begin
          e_mon = exp_q.pop_front();
          chk("wr_addr", mem_addr, e_mon.a);
          chk("wr_data", mem_wdata, e_mon.d);
        end
      end
      if (mem_wr2) begin
        if (w2_idx < 4) begin
          chk("n2_addr", mem_addr2, 64'(8 + w2_idx));
          chk("n2_data", mem_wdata2, 64'($unsigned(c2_exp[w2_idx])));
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL n2_unexpected_wr: write at %0h, none required", mem_addr2);
        end
        w2_idx++;
      end
    end
  end

  task automatic load(input int ba, input int bb, input mat_t A, input mat_t B);
    for (int x = 0; x < 18; x++) begin
      @(negedge CLK);
      ld_en   = 1'b1;
      ld_addr = (x < 9) ? 16'(ba + x) : 16'(bb + x - 9);
      ld_data = (x < 9) ? A[x] : B[x-9];
    end
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  task automatic run_job(input int ba, input int bb, input int bc, input mat_t A, input mat_t B,
                         input bit inj, input bit dstart, input int abort_at);
    bit exp_ovf = 0;
    bit busy_ok = 1;
    int cnt;
    logic signed [66:0] s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = dot(A, B, i, j);
        if (!in_range(s)) exp_ovf = 1;
        exp_q.push_back('{16'(bc + i*3 + j), res(s)});
      end
    @(negedge CLK);
    base_a = 16'(ba);
    base_b = 16'(bb);
    base_c = 16'(bc);
    start  = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    cnt = 1;
    while (cnt < LAT + 20) begin
      @(negedge CLK);
      if (done) break;
      if (!busy) busy_ok = 0;
      if (cnt == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wr", mem_wr, 0);
        chk("abort_rd", mem_rd, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_ovf", ovf, 0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        repeat (5) @(negedge CLK);
        chk("abort_idle_busy", busy, 0);
        return;
      end
      start = inj && (cnt == 10 || cnt == 40);
      if (cnt == 20) begin
        base_a = 16'($urandom());
        base_b = 16'($urandom());
        base_c = 16'($urandom());
      end
      cnt++;
    end
    start = 1'b0;
    chk("done_edge", cnt, LAT);
    chk("busy_during_job", busy_ok, 1);
    chk("ovf", ovf, exp_ovf);
    chk("writes_pending", exp_q.size(), 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk("c_mem", mem[16'(bc + i*3 + j)], res(dot(A, B, i, j)));
    if (dstart) begin
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("done_pulse_width", done, 0);
      chk("start_in_done_busy", busy, 0);
      @(negedge CLK);
      chk("start_in_done_idle", busy, 0);
    end
  endtask

  initial begin
    int cnt;
    for (int x = 0; x < 9; x++) begin
      A1[x] = x + 1;
      AO[x] = 32'h4000_0000;
      BO[x] = 2;
    end

    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 1'b1;

    // A = B = 1..9
    load(0, 9, A1, A1);
    run_job(0, 9, 18, A1, A1, 0, 0, 0);
    chk("lit_c00", mem[18], 30);
    chk("lit_c01", mem[19], 36);
    chk("lit_c02", mem[20], 42);
    chk("lit_c10", mem[21], 66);
    chk("lit_c11", mem[22], 81);
    chk("lit_c12", mem[23], 96);
    chk("lit_c20", mem[24], 102);
    chk("lit_c21", mem[25], 126);
    chk("lit_c22", mem[26], 150);
    chk("lit_ovf0", ovf, 0);

    // 3 * 2^30 * 2 = 3 * 2^31 overflows
    load(100, 109, AO, BO);
    run_job(100, 109, 118, AO, BO, 0, 0, 0);
    chk("lit_ovf1", ovf, 1);
`ifdef MATMUL_SAT_EN
    chk("lit_ovf_elem", mem[118], 32'h7FFF_FFFF);
`else
    chk("lit_ovf_elem", mem[118], 32'h8000_0000);
`endif

    run_job(0, 9, 30, A1, A1, 0, 0, 0);
    chk("lit_ovf_cleared", ovf, 0);

    for (int x = 0; x < 9; x++) begin
      AR[x] = int'($urandom_range(0, 2000)) - 1000;
      BR[x] = int'($urandom_range(0, 2000)) - 1000;
      AS[x] = int'($urandom());
      BS[x] = int'($urandom_range(0, 200)) - 100;
    end
    load(300, 309, AR, BR);
    load(400, 409, AS, BS);
    run_job(300, 309, 318, AR, BR, 1, 0, 0);
    run_job(400, 409, 418, AS, BS, 0, 0, 0);

    run_job(0, 9, 40, A1, A1, 0, 1, 0);

    run_job(300, 309, 318, AR, BR, 0, 0, 50);
    run_job(300, 309, 318, AR, BR, 0, 0, 0);

    load(200, 209, AS, AR);
    run_job(200, 209, 16'hFFFC, AS, AR, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      int ba;
      for (int x = 0; x < 9; x++) begin
        AR[x] = (r < 2) ? int'($urandom_range(0, 200000)) - 100000 : int'($urandom());
        BR[x] = (r < 2) ? int'($urandom_range(0, 200000)) - 100000 : int'($urandom());
      end
      ba = int'($urandom_range(1000, 60000));
      load(ba, ba + 9, AR, BR);
      run_job(ba, ba + 9, ba + 18, AR, BR, r[0], 0, 0);
    end

    // N=2 instance, signed operands
    @(negedge CLK);
    start2 = 1'b1;
    @(posedge CLK);
    #1 start2 = 1'b0;
    cnt = 1;
    while (cnt < LAT2 + 20) begin
      @(negedge CLK);
      if (done2) break;
      cnt++;
    end
    chk("n2_done_edge", cnt, LAT2);
    chk("n2_ovf", ovf2, 0);
    chk("n2_busy", busy2, 1);
    @(negedge CLK);
    chk("n2_writes", w2_idx, 4);
    chk("n2_idle", busy2, 0);

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
